piso_shift_tx: RTL and testbench
================================

Name: piso_shift_tx

Overview:
Parallel-in serial-out transmitter, the sending end of the serial link whose receive side deserialises into a parallel register.
- Accepts a WIDTH-bit parallel word through a valid/ready handshake.
- Shifts the word out one bit per clock with a per-bit valid strobe and an end-of-frame marker.
- Sits between a parallel data source and the serial line feeding a SIPO/PIPO receive register.

Parameters:
WIDTH, 4, data word width in bits; legal range 2..32
MSB_FIRST, 1, 1 = bit WIDTH-1 transmitted first; 0 = bit 0 transmitted first

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset, asynchronous assert, active-low (0 = reset)
pi  input  WIDTH  parallel word to transmit
load_valid  input  1  source has a word on pi
load_ready  output  1  transmitter can accept a word this cycle
so  output  1  serial data out
so_valid  output  1  so carries a frame bit this cycle
so_last  output  1  so carries the final bit of the frame
busy  output  1  frame in progress

Behaviour:
- State machine states: IDLE, SHIFT.
- Reset (rst=0, asynchronous) forces IDLE, shift register = 0, bit counter = 0.
- Reset values: so=0, so_valid=0, so_last=0, busy=0, load_ready=1.
- Deassertion of rst takes effect at the next rising edge.
- load_ready is combinational: 1 in IDLE, 1 in SHIFT only while so_last=1, 0 otherwise.
- Accept condition: load_valid && load_ready at a rising edge. pi is captured into the shift register and the bit counter is cleared; state becomes SHIFT.
- Latency: first bit appears on so in the cycle after the accepting edge.
- SHIFT timing:
  - one bit per cycle; so_valid=1 and busy=1 throughout the frame.
  - counter runs 0..WIDTH-1; so_last=1 when counter = WIDTH-1.
  - so, so_valid and so_last are all registered outputs, driven from the shift register and counter.
- Bit order: MSB_FIRST=1 drives so from the register MSB and shifts left with zero fill. MSB_FIRST=0 drives so from the LSB and shifts right with zero fill.
- End of frame, i.e. at the edge where so_last=1:
  - if load_valid=1, the next word is accepted and its first bit follows with no idle gap (back-to-back frames);
  - otherwise the block returns to IDLE with so=0, so_valid=0, so_last=0, busy=0.
- load_valid while load_ready=0: ignored, no capture. The source must hold the word until the handshake completes.
- pi changes outside the accept edge have no effect on the frame in flight.
- Reset mid-frame: the frame is aborted immediately and all outputs take their reset values. No partial frame resumes after reset.
- Counter width: $clog2(WIDTH+1) bits. It never wraps past the frame length.

Optional Feature:
Macro: PISO_PARITY_EN
- Defined:
  - one extra even-parity bit is sent after the data bits; frame length is WIDTH+1 cycles;
  - the parity bit is the XOR of the captured word, computed at capture time;
  - so_last asserts on the parity bit only, and the back-to-back load_ready window moves to the parity cycle.
- Not defined: frame length is WIDTH cycles, with no parity logic or storage.

Test Plan:
1. WIDTH=4, MSB_FIRST=1, reset, then load 4'b1010 -> cycles 1-4 after accept: so=1,0,1,0 with so_valid=1; so_last only on cycle 4; then idle with so_valid=0 and load_ready=1.
2. Back-to-back: 4'b1111 accepted, load_valid held with pi=4'b1100 through so_last -> 8 consecutive valid bits 1,1,1,1,1,1,0,0 with no gap; so_last on bits 4 and 8.
3. MSB_FIRST=0, load 4'b1100 -> so=0,0,1,1; so_last on the 4th bit.
4. load_valid=1 with pi=4'b0110 during bits 1-3 of a 4'b1001 frame -> load_ready=0 and output stays 1,0,0,1. The new word is accepted only at the so_last edge, then 0,1,1,0 follows.
5. Reset asserted (rst=0) after bit 2 of 4'b1011 -> so, so_valid, so_last and busy drop to 0 without waiting for a clock edge. After release, idle with load_ready=1 and no residual bits.
6. PISO_PARITY_EN defined: load 4'b1010 -> so=1,0,1,0,0 with so_last on the 5th bit. Load 4'b1011 -> so=1,0,1,1,1.

Source files
------------

// File: rtl/piso_shift_tx.sv
// Parallel-in serial-out transmitter: valid/ready word load, one bit per clock with per-bit
// valid and end-of-frame strobes. Define PISO_PARITY_EN to append an even-parity bit per frame.
module piso_shift_tx #(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] pi,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             so,
   output logic             so_valid,
   output logic             so_last,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH + 1);
`ifdef PISO_PARITY_EN
   localparam int FRAME_LEN = WIDTH + 1;
`else
   localparam int FRAME_LEN = WIDTH;
`endif
   localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] SHIFT = 1'b1;

   logic [0:0]       state;
   logic [WIDTH-1:0] sreg;   // bits still waiting to go out, next one at the shift end
   logic [CW-1:0]    cnt;    // index of the bit currently on so
`ifdef PISO_PARITY_EN
   logic             par;
`endif

   logic             accept;
   logic             first_bit;
   logic [WIDTH-1:0] pi_rest;
   logic             sreg_head;
   logic [WIDTH-1:0] sreg_next;
   logic [CW-1:0]    cnt_inc;
   logic             next_bit;

   assign load_ready = (state == IDLE) || so_last;
   assign accept     = load_valid && load_ready;
   assign busy       = (state == SHIFT);
   assign cnt_inc    = cnt + 1'b1;

   // The first bit leaves straight from pi at the accept edge, so only the rest is stored.
   assign first_bit = MSB_FIRST ? pi[WIDTH-1] : pi[0];
   assign pi_rest   = MSB_FIRST ? {pi[WIDTH-2:0], 1'b0} : {1'b0, pi[WIDTH-1:1]};
   assign sreg_head = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
   assign sreg_next = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};

`ifdef PISO_PARITY_EN
   assign next_bit = (cnt_inc == CW'(WIDTH)) ? par : sreg_head;
`else
   assign next_bit = sreg_head;
`endif

   // NOTE: every register here updates with <= so all reads in this block see pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         sreg     <= '0;
         cnt      <= '0;
         so       <= 1'b0;
         so_valid <= 1'b0;
         so_last  <= 1'b0;
`ifdef PISO_PARITY_EN
         par      <= 1'b0;
`endif
      end else if (accept) begin
         state    <= SHIFT;
         sreg     <= pi_rest;
         cnt      <= '0;
         so       <= first_bit;
         so_valid <= 1'b1;
         so_last  <= 1'b0;
`ifdef PISO_PARITY_EN
         par      <= ^pi;
`endif
      end else if (state == SHIFT) begin
         if (so_last) begin
            state    <= IDLE;
            sreg     <= '0;
            cnt      <= '0;
            so       <= 1'b0;
            so_valid <= 1'b0;
            so_last  <= 1'b0;
         end else begin
            sreg     <= sreg_next;
            cnt      <= cnt_inc;
            so       <= next_bit;
            so_last  <= (cnt_inc == LAST_IDX);
         end
      end
   end

endmodule

// File: tb/tb_piso_shift_tx.sv
// Directed bench for piso_shift_tx: table of per-cycle vectors on an MSB-first instance plus
// hand-written reset-abort and LSB-first sequences. Expectations follow PISO_PARITY_EN.
module tb_piso_shift_tx;

   localparam int WIDTH = 4;
`ifdef PISO_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic [WIDTH-1:0] pi;
   logic             load_valid;

   logic a_ready, a_so, a_sov, a_last, a_busy;
   logic b_ready, b_so, b_sov, b_last, b_busy;
   logic [4:0] a_out, b_out;

   // Packed order everywhere: {so, so_valid, so_last, busy, load_ready}
   assign a_out = {a_so, a_sov, a_last, a_busy, a_ready};
   assign b_out = {b_so, b_sov, b_last, b_busy, b_ready};

   piso_shift_tx #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut_msb (
      .clk(clk), .rst(rst), .pi(pi), .load_valid(load_valid), .load_ready(a_ready),
      .so(a_so), .so_valid(a_sov), .so_last(a_last), .busy(a_busy)
   );

   piso_shift_tx #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dut_lsb (
      .clk(clk), .rst(rst), .pi(pi), .load_valid(load_valid), .load_ready(b_ready),
      .so(b_so), .so_valid(b_sov), .so_last(b_last), .busy(b_busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic       lv;
      logic [3:0] word;
      logic [4:0] exp;
   } vec_t;

   vec_t vq[$];
   int   total = 0;
   int   bad   = 0;

   task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: so/valid/last/busy/ready got %b expected %b", name, act, exp);
      end
   endtask

   function automatic void push(input string n, input logic lv, input logic [3:0] w,
                                input logic s, input logic v, input logic l,
                                input logic b, input logic r);
      vec_t t;
      t.name = n;
      t.lv   = lv;
      t.word = w;
      t.exp  = {s, v, l, b, r};
      vq.push_back(t);
   endfunction

   // Inputs change 1 time unit after a rising edge; outputs sampled 1 unit after the next one.
   task automatic step(input logic lv, input logic [3:0] w);
      load_valid = lv;
      pi         = w;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Single frame 1010, pi wiggling mid-frame without load_valid
      push("t1_bit1", 1, 4'b1010, 1, 1, 0, 1, 0);
      push("t1_bit2", 0, 4'b0101, 0, 1, 0, 1, 0);
      push("t1_bit3", 0, 4'b0101, 1, 1, 0, 1, 0);
      push("t1_bit4", 0, 4'b1111, 0, 1, !PAR, 1, !PAR);
      if (PAR) push("t1_parity", 0, 4'b1111, 0, 1, 1, 1, 1);
      push("t1_idle", 0, 4'b0000, 0, 0, 0, 0, 1);
      push("t1_idle2", 0, 4'b0000, 0, 0, 0, 0, 1);
      // Back-to-back 1111 then 1100, load_valid held throughout
      push("t2_bit1", 1, 4'b1111, 1, 1, 0, 1, 0);
      push("t2_bit2", 1, 4'b1100, 1, 1, 0, 1, 0);
      push("t2_bit3", 1, 4'b1100, 1, 1, 0, 1, 0);
      push("t2_bit4", 1, 4'b1100, 1, 1, !PAR, 1, !PAR);
      if (PAR) push("t2_parity", 1, 4'b1100, 0, 1, 1, 1, 1);
      push("t2_bit5", 1, 4'b1100, 1, 1, 0, 1, 0);
      push("t2_bit6", 0, 4'b0000, 1, 1, 0, 1, 0);
      push("t2_bit7", 0, 4'b0000, 0, 1, 0, 1, 0);
      push("t2_bit8", 0, 4'b0000, 0, 1, !PAR, 1, !PAR);
      if (PAR) push("t2_parity2", 0, 4'b0000, 0, 1, 1, 1, 1);
      push("t2_idle", 0, 4'b0000, 0, 0, 0, 0, 1);
      // 1001 frame with 0110 offered early: ignored until the last bit
      push("t4_bit1", 1, 4'b1001, 1, 1, 0, 1, 0);
      push("t4_bit2", 1, 4'b0110, 0, 1, 0, 1, 0);
      push("t4_bit3", 1, 4'b0110, 0, 1, 0, 1, 0);
      push("t4_bit4", 1, 4'b0110, 1, 1, !PAR, 1, !PAR);
      if (PAR) push("t4_parity", 1, 4'b0110, 0, 1, 1, 1, 1);
      push("t4_next1", 1, 4'b0110, 0, 1, 0, 1, 0);
      push("t4_next2", 0, 4'b0000, 1, 1, 0, 1, 0);
      push("t4_next3", 0, 4'b0000, 1, 1, 0, 1, 0);
      push("t4_next4", 0, 4'b0000, 0, 1, !PAR, 1, !PAR);
      if (PAR) push("t4_parity2", 0, 4'b0000, 0, 1, 1, 1, 1);
      push("t4_idle", 0, 4'b0000, 0, 0, 0, 0, 1);
      // Odd-parity word 1011: parity bit is 1
      push("t6_bit1", 1, 4'b1011, 1, 1, 0, 1, 0);
      push("t6_bit2", 0, 4'b0000, 0, 1, 0, 1, 0);
      push("t6_bit3", 0, 4'b0000, 1, 1, 0, 1, 0);
      push("t6_bit4", 0, 4'b0000, 1, 1, !PAR, 1, !PAR);
      if (PAR) push("t6_parity", 0, 4'b0000, 1, 1, 1, 1, 1);
      push("t6_idle", 0, 4'b0000, 0, 0, 0, 0, 1);

      rst        = 1'b0;
      load_valid = 1'b0;
      pi         = '0;
      #2;
      check("reset_msb", a_out, 5'b00001);
      check("reset_lsb", b_out, 5'b00001);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("post_reset_idle", a_out, 5'b00001);

      foreach (vq[i]) begin
         step(vq[i].lv, vq[i].word);
         check(vq[i].name, a_out, vq[i].exp);
      end

      // Reset mid-frame after bit 2 of 1011: outputs drop without a clock edge
      step(1, 4'b1011);
      check("t5_bit1", a_out, 5'b11010);
      step(0, 4'b0000);
      check("t5_bit2", a_out, 5'b01010);
      #2;
      rst = 1'b0;
      #1;
      check("t5_async_abort", a_out, 5'b00001);
      step(1, 4'b1010);
      check("t5_held_in_reset", a_out, 5'b00001);
      load_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      step(0, 4'b0000);
      check("t5_idle_after", a_out, 5'b00001);
      step(0, 4'b0000);
      check("t5_no_residual", a_out, 5'b00001);
      step(1, 4'b1010);
      check("t5_fresh_bit1", a_out, 5'b11010);
      step(0, 4'b0000);
      check("t5_fresh_bit2", a_out, 5'b01010);
      step(0, 4'b0000);
      step(0, 4'b0000);
      if (PAR) step(0, 4'b0000);
      step(0, 4'b0000);
      check("t5_fresh_done", a_out, 5'b00001);

      // LSB-first instance: 1100 -> 0,0,1,1 then 0001 -> 1,0,0,0
      step(1, 4'b1100);
      check("t3_bit1", b_out, 5'b01010);
      step(0, 4'b0000);
      check("t3_bit2", b_out, 5'b01010);
      step(0, 4'b0000);
      check("t3_bit3", b_out, 5'b11010);
      step(0, 4'b0000);
      check("t3_bit4", b_out, {1'b1, 1'b1, !PAR, 1'b1, !PAR});
      if (PAR) begin
         step(0, 4'b0000);
         check("t3_parity", b_out, 5'b01111);
      end
      step(0, 4'b0000);
      check("t3_idle", b_out, 5'b00001);
      step(1, 4'b0001);
      check("t3b_bit1", b_out, 5'b11010);
      step(0, 4'b1111);
      check("t3b_bit2", b_out, 5'b01010);
      step(0, 4'b1111);
      check("t3b_bit3", b_out, 5'b01010);
      step(0, 4'b0000);
      check("t3b_bit4", b_out, {1'b0, 1'b1, !PAR, 1'b1, !PAR});
      if (PAR) begin
         step(0, 4'b0000);
         check("t3b_parity", b_out, 5'b11111);
      end
      step(0, 4'b0000);
      check("t3b_idle", b_out, 5'b00001);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
